// File: rtl/slice_store_if.sv
// Bus bundle between the slice store, its stream neighbours and the addRc controller.
// The master modport is the side that drives strobes and stream inputs. The slave
// modport is the store itself.
interface slice_store_if #(
   parameter int unsigned LANES = 25,
   parameter int unsigned AW    = 6,
   parameter int unsigned LW    = 5
) ();

   // Input stream (FILL)
   logic             in_valid;
   logic [LANES-1:0] in_slice;
   logic             in_ready;

   // Controller read strobe
   logic             ld_fr;
   logic [AW-1:0]    rd_addr;
   logic [LANES-1:0] rd_slice;

   // Controller single-bit write strobe
   logic             en_fw;
   logic [AW-1:0]    wr_addr;
   logic [LW-1:0]    wr_lane;
   logic             wr_bit;

   // Controller completion and store status
   logic             op_done;
   logic             loaded;

   // Output stream (DRAIN)
   logic             out_valid;
   logic [LANES-1:0] out_slice;
   logic             out_ready;

   modport master (
      output in_valid, in_slice, ld_fr, rd_addr, en_fw, wr_addr, wr_lane, wr_bit,
             op_done, out_ready,
      input  in_ready, rd_slice, loaded, out_valid, out_slice
   );

   modport slave (
      input  in_valid, in_slice, ld_fr, rd_addr, en_fw, wr_addr, wr_lane, wr_bit,
             op_done, out_ready,
      output in_ready, rd_slice, loaded, out_valid, out_slice
   );

endinterface

// File: rtl/slice_store_responder.sv
// Slice-organised state store for the addRc datapath. The store fills SLICES x LANES bits
// from the input stream. It then services controller read/bit-write strobes until op_done,
// and finally drains every slice, in order, to the output stream. The controller owns all
// addressing. This block only owns storage and the fill/drain pointers.
module slice_store_responder #(
   parameter int unsigned SLICES = 64,
   parameter int unsigned LANES  = 25,
   parameter int unsigned AW     = 6,
   parameter int unsigned LW     = 5
) (
   input  logic           clk,
   input  logic           rst,
   slice_store_if.slave   bus
);

   typedef enum logic [1:0] {
      StFill  = 2'd0,
      StServe = 2'd1,
      StDrain = 2'd2
   } state_e;

   state_e           r_state;
   state_e           w_state_next;

   logic [AW-1:0]    r_fptr;
   logic [AW-1:0]    w_fptr_next;
   logic [AW-1:0]    r_dptr;
   logic [AW-1:0]    w_dptr_next;

   // Storage is intentionally not reset; FILL overwrites every slice before use.
   logic [LANES-1:0] r_mem [SLICES];
   logic [LANES-1:0] r_rd_slice;

   logic             w_fill_we;
   logic             w_bit_we;
   logic             w_rd_en;
   logic             w_in_ready;
   logic             w_loaded;
   logic             w_out_valid;
   logic [LANES-1:0] w_lane_mask;
   logic [LANES-1:0] w_wr_word;

   // Decode the write lane to a one-hot mask; an out-of-range lane yields an all-zero mask.
   always_comb begin
      w_lane_mask = '0;
      for (int i = 0; i < LANES; i++) begin
         w_lane_mask[i] = (bus.wr_lane == LW'(i));
      end
   end

   // Read-modify-write word for the single-bit update of the addressed slice.
   always_comb begin
      w_wr_word = (r_mem[bus.wr_addr] & ~w_lane_mask) | (w_lane_mask & {LANES{bus.wr_bit}});
   end

   // Next-state, pointer and strobe-qualification logic for the FILL/SERVE/DRAIN cycle.
   always_comb begin
      w_state_next = r_state;
      w_fptr_next  = r_fptr;
      w_dptr_next  = r_dptr;
      w_fill_we    = 1'b0;
      w_bit_we     = 1'b0;
      w_rd_en      = 1'b0;
      w_in_ready   = 1'b0;
      w_loaded     = 1'b0;
      w_out_valid  = 1'b0;

      unique case (r_state)
         StFill: begin
            w_in_ready = 1'b1;
            if (bus.in_valid) begin
               w_fill_we   = 1'b1;
               w_fptr_next = r_fptr + AW'(1);
               // Last slice: pointer wraps to 0 on its own since SLICES is a power of two.
               if (&r_fptr) begin
                  w_state_next = StServe;
               end
            end
         end

         StServe: begin
            w_loaded = 1'b1;
            w_rd_en  = bus.ld_fr;
            w_bit_we = bus.en_fw & (|w_lane_mask);
            // Strobes in the op_done cycle are still serviced above.
            if (bus.op_done) begin
               w_state_next = StDrain;
               w_dptr_next  = '0;
            end
         end

         StDrain: begin
            w_out_valid = 1'b1;
            if (bus.out_ready) begin
               w_dptr_next = r_dptr + AW'(1);
               if (&r_dptr) begin
                  w_state_next = StFill;
               end
            end
         end

         default: begin
            w_state_next = StFill;
         end
      endcase
   end

   // State and fill/drain pointer registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= StFill;
         r_fptr  <= '0;
         r_dptr  <= '0;
      end else begin
         r_state <= w_state_next;
         r_fptr  <= w_fptr_next;
         r_dptr  <= w_dptr_next;
      end
   end

   // Registered read port; a same-cycle bit write lands after this samples (read-old).
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_slice <= '0;
      end else if (w_rd_en) begin
         r_rd_slice <= r_mem[bus.rd_addr];
      end
   end

   // Storage writes: whole-slice fills in FILL, single-lane updates in SERVE.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (w_fill_we) begin
            r_mem[r_fptr] <= bus.in_slice;
         end
         if (w_bit_we) begin
            r_mem[bus.wr_addr] <= w_wr_word;
         end
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.loaded    = w_loaded;
   assign bus.rd_slice  = r_rd_slice;
   assign bus.out_valid = w_out_valid;
   // Combinational drain read; stable during stalls because r_dptr only moves on handshake.
   assign bus.out_slice = r_mem[r_dptr];

endmodule
